// File: rtl/spi_master.sv
// spi_master: single-frame SPI bus master with configurable mode and clock divider.
//
// A frame runs through four phases: IDLE, SETUP (cs low, sclk idle), SHIFT (DATA_WIDTH sclk
// pulses) and HOLD (cs still low, sclk idle). Every output is a register. A frame takes
// exactly (2*DATA_WIDTH+2)*CLK_DIV cycles from the accepting edge to the done pulse.
//
// Parameters:
//   DATA_WIDTH  frame length in bits (2..32)
//   CLK_DIV     sclk half-period in clk cycles (>= 1)
//   CPOL        sclk idle level
//   CPHA        0: sample on leading edge, 1: sample on trailing edge
//
// Ports:
//   i_clk             system clock, rising edge
//   i_reset           synchronous active-high reset; aborts any frame
//   i_start_transfer  frame request, honoured only when idle
//   i_data_to_tx      frame to send, captured on the accepting edge
//   o_data_to_rx      last completely received frame
//   o_busy            high while a frame is in progress
//   o_done            one-cycle pulse at frame completion
//   o_sclk            serial clock
//   o_mosi            serial data out (0 when idle)
//   i_miso            serial data in
//   o_cs              chip select, active low
//
// Optional feature: define SPI_LSB_FIRST_EN to shift frames LSB first (default MSB first).
// Frame timing is the same either way.
module spi_master #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CLK_DIV    = 4,
  parameter bit          CPOL       = 1'b0,
  parameter bit          CPHA       = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start_transfer,
  input  logic [DATA_WIDTH-1:0] i_data_to_tx,
  output logic [DATA_WIDTH-1:0] o_data_to_rx,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_sclk,
  output logic                  o_mosi,
  input  logic                  i_miso,
  output logic                  o_cs
);

  localparam int unsigned DivW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned HalfW = $clog2(2 * DATA_WIDTH);

  localparam logic [DivW-1:0]  DivLast       = DivW'(CLK_DIV - 1);
  // Index of the final half-period of SHIFT (idle half of the last pulse).
  localparam logic [HalfW-1:0] HalfLast      = HalfW'(2 * DATA_WIDTH - 1);
  // Phase whose end produces the final trailing edge.
  localparam logic [HalfW-1:0] HalfLastTrail = HalfW'(2 * DATA_WIDTH - 2);

  typedef enum logic [1:0] {StIdle, StSetup, StShift, StHold} state_e;

  // Bit-order helpers: the only place the shift direction is decided.
  function automatic logic head_bit(input logic [DATA_WIDTH-1:0] v);
`ifdef SPI_LSB_FIRST_EN
    return v[0];
`else
    return v[DATA_WIDTH-1];
`endif
  endfunction

  function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] v);
`ifdef SPI_LSB_FIRST_EN
    return v >> 1;
`else
    return v << 1;
`endif
  endfunction

  function automatic logic [DATA_WIDTH-1:0] insert(input logic [DATA_WIDTH-1:0] v,
                                                   input logic b);
`ifdef SPI_LSB_FIRST_EN
    return {b, v[DATA_WIDTH-1:1]};
`else
    return {v[DATA_WIDTH-2:0], b};
`endif
  endfunction

  state_e                r_state;
  logic [DivW-1:0]       r_div;
  logic [HalfW-1:0]      r_half;
  logic [DATA_WIDTH-1:0] r_shift;  // bits still to be presented, head = next bit
  logic [DATA_WIDTH-1:0] r_rx;
  logic [DATA_WIDTH-1:0] r_data_to_rx;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_sclk;
  logic                  r_mosi;
  logic                  r_cs;
  logic                  w_phase_end;

  assign w_phase_end = (r_div == DivLast);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= StIdle;
      r_div        <= '0;
      r_half       <= '0;
      r_shift      <= '0;
      r_rx         <= '0;
      r_data_to_rx <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_sclk       <= CPOL;
      r_mosi       <= 1'b0;
      r_cs         <= 1'b1;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          r_mosi <= 1'b0;
          if (i_start_transfer) begin
            r_state <= StSetup;
            r_cs    <= 1'b0;
            r_busy  <= 1'b1;
            r_div   <= '0;
            r_half  <= '0;
            r_rx    <= '0;
            if (CPHA == 1'b0) begin
              // First bit must already be on the wire before the first leading edge.
              r_mosi  <= head_bit(i_data_to_tx);
              r_shift <= advance(i_data_to_tx);
            end else begin
              r_shift <= i_data_to_tx;
            end
          end
        end

        StSetup: begin
          if (w_phase_end) begin
            // First leading edge.
            r_div   <= '0;
            r_half  <= '0;
            r_sclk  <= ~CPOL;
            r_state <= StShift;
            if (CPHA == 1'b0) begin
              r_rx <= insert(r_rx, i_miso);
            end else begin
              r_mosi  <= head_bit(r_shift);
              r_shift <= advance(r_shift);
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end

        StShift: begin
          if (w_phase_end) begin
            r_div <= '0;
            if (r_half == HalfLast) begin
              r_state <= StHold;
            end else begin
              r_half <= r_half + 1'b1;
              r_sclk <= ~r_sclk;
              if (!r_half[0]) begin
                // Even phases end in a trailing edge.
                if (CPHA == 1'b1) begin
                  r_rx <= insert(r_rx, i_miso);
                end else if (r_half != HalfLastTrail) begin
                  r_mosi  <= head_bit(r_shift);
                  r_shift <= advance(r_shift);
                end
              end else begin
                if (CPHA == 1'b1) begin
                  r_mosi  <= head_bit(r_shift);
                  r_shift <= advance(r_shift);
                end else begin
                  r_rx <= insert(r_rx, i_miso);
                end
              end
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end

        StHold: begin
          if (w_phase_end) begin
            r_div        <= '0;
            r_state      <= StIdle;
            r_cs         <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b1;
            r_mosi       <= 1'b0;
            r_data_to_rx <= r_rx;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end

        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_data_to_rx = r_data_to_rx;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_sclk       = r_sclk;
  assign o_mosi       = r_mosi;
  assign o_cs         = r_cs;

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
Parameters:
REQ-001 SHALL provide parameter DATA_WIDTH, default 16, frame length in bits (legal range 2..32).
REQ-002 SHALL provide parameter CLK_DIV, default 4, sclk half-period in clk cycles (legal range ≥1).
REQ-003 SHALL provide parameter CPOL, default 0, sclk idle level.
REQ-004 SHALL provide parameter CPHA, default 0: 0 = sample on leading edge, 1 = sample on trailing edge.
Ports:
REQ-005 SHALL provide: clk  input  1  system clock; all logic on rising edge.
REQ-006 SHALL provide: reset  input  1  synchronous, active-high reset.
REQ-007 SHALL provide: start_transfer  input  1  request a frame; honoured only in IDLE.
REQ-008 SHALL provide: data_to_tx  input  DATA_WIDTH  frame to send; captured on the accepting edge.
REQ-009 SHALL provide: data_to_rx  output  DATA_WIDTH  last complete received frame.
REQ-010 SHALL provide: busy  output  1  high while a frame is in progress.
REQ-011 SHALL provide: done  output  1  one-cycle pulse at frame completion.
REQ-012 SHALL provide: sclk  output  1  serial clock.
REQ-013 SHALL provide: mosi  output  1  serial data out.
REQ-014 SHALL provide: miso  input  1  serial data in.
REQ-015 SHALL provide: cs  output  1  chip select, active low.

Function
REQ-016 SHALL implement FSM IDLE -> SETUP -> SHIFT -> HOLD -> IDLE; all outputs registered.
REQ-017 IDLE: start_transfer=1 at edge N SHALL latch data_to_tx into the shift register and enter SETUP; cs=0 and busy=1 from edge N.
REQ-018 SETUP SHALL last CLK_DIV cycles with sclk=CPOL; with CPHA=0, mosi SHALL present the first bit throughout SETUP.
REQ-019 SHIFT SHALL generate exactly DATA_WIDTH sclk pulses, each level lasting CLK_DIV cycles; no glitches or runt pulses.
REQ-020 CPHA=0: miso sampled on the clk edge producing each leading sclk edge; mosi advanced on each trailing edge except the last.
REQ-021 CPHA=1: mosi advanced on each leading edge (first bit driven on the first leading edge); miso sampled on each trailing edge.
REQ-022 Bit order SHALL be MSB first (see REQ-033 for the exception).
REQ-023 After the last sclk edge, sclk SHALL return to CPOL and the FSM enters HOLD for CLK_DIV cycles with cs=0.
REQ-024 HOLD exit SHALL, on the same edge: set cs=1, busy=0, done=1 for one cycle, and load data_to_rx with the received frame.
REQ-025 data_to_rx SHALL hold its value at all other times.
REQ-026 Frame length SHALL be exactly (2*DATA_WIDTH+2)*CLK_DIV cycles from acceptance to done.
REQ-027 start_transfer while busy=1 SHALL be ignored; no queuing. Changes to data_to_tx during a frame SHALL have no effect.
REQ-028 start_transfer held high SHALL begin a new frame on the cycle after done; cs SHALL be high for at least one cycle between frames.
REQ-029 mosi SHALL be 0 in IDLE.

Reset
REQ-030 On reset=1 at a clk edge: state=IDLE, cs=1, sclk=CPOL, mosi=0, busy=0, done=0, data_to_rx=0, counters=0.
REQ-031 Reset mid-frame SHALL abort the frame immediately: no done pulse is produced and data_to_rx is cleared.
REQ-032 Reset SHALL take priority over start_transfer on the same edge.

Configuration
REQ-033 Macro SPI_LSB_FIRST_EN: when defined, frames SHALL be transmitted and received LSB first; when undefined, MSB first. Frame timing SHALL be identical in both cases.

Verification
REQ-034 Scenario 1: defaults, data_to_tx=16'hA5A5, miso looped to mosi -> 16 sclk pulses, done after 136 cycles, data_to_rx=16'hA5A5.
REQ-035 Scenario 2: CPOL=1, CPHA=1, DATA_WIDTH=8, CLK_DIV=2, miso stuck 1, tx 8'h3C -> sclk idles high, mosi bit sequence 0,0,1,1,1,1,0,0, data_to_rx=8'hFF, done at cycle 36.
REQ-036 Scenario 3: start_transfer pulsed again mid-frame with different data -> ignored; exactly one done; mosi matches the first frame only.
REQ-037 Scenario 4: reset asserted at sclk pulse 7 -> next cycle cs=1, sclk=CPOL, busy=0; no done; data_to_rx=0.
REQ-038 Scenario 5: start_transfer held high for 3 frames -> 3 done pulses; cs high at least 1 cycle between frames.
REQ-039 Scenario 6: SPI_LSB_FIRST_EN defined, tx 16'h0001, loopback -> mosi=1 on the first bit, data_to_rx=16'h0001.
